// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states, latencies.
package mdu_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   // Ops that occupy the unit for multiple cycles and stall MD readers
   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi, lo}.
// A zero divisor returns the current hi/lo unchanged; the signed overflow
// case 0x8000_0000 / -1 yields quotient 0x8000_0000, remainder 0.
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] hold_hi,
   input  logic [31:0] hold_lo,
   output logic [63:0] result
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic signed [31:0] divisor_s;
   logic        [31:0] divisor_u;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
   assign prod_u = {32'd0, src_a} * {32'd0, src_b};

   assign div_zero = (src_b == 32'd0);
   assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

   // Substituting a divisor of 1 keeps the dividers defined and, for the
   // overflow case, directly gives quotient = dividend and remainder = 0.
   assign divisor_s = (div_zero || div_ovf) ? 32'sd1 : $signed(src_b);
   assign divisor_u = div_zero ? 32'd1 : src_b;

   assign quo_s = $signed(src_a) / divisor_s;
   assign rem_s = $signed(src_a) % divisor_s;
   assign quo_u = src_a / divisor_u;
   assign rem_u = src_a % divisor_u;

   // Result select per opcode
   always_comb begin
      result = {hold_hi, hold_lo};
      case (md_op)
         MD_MULT:  result = prod_s;
         MD_MULTU: result = prod_u;
         MD_DIV:   if (!div_zero) result = {rem_s, quo_s};
         MD_DIVU:  if (!div_zero) result = {rem_u, quo_u};
         default:  result = {hold_hi, hold_lo};
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latency counter, pending result, HI/LO registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepting commands; MTHI/MTLO write in one cycle
// ST_BUSY | counting down; result held in pend_hi/pend_lo until done
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   mdu_state_e       state;
   mdu_state_e       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic [63:0]      arith_res;
   logic             accept_long;
   logic             accept_mthi;
   logic             accept_mtlo;
   logic             complete;
   logic             is_mult;

   mdu_arith u_arith (
      .md_op   (md_op),
      .src_a   (src_a),
      .src_b   (src_b),
      .hold_hi (hi),
      .hold_lo (lo),
      .result  (arith_res)
   );

   assign is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: leave BUSY on the terminal count of 1
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept_long) state_nxt = ST_BUSY;
         ST_BUSY: if (complete)    state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs and command acceptance; commands are only taken in IDLE
   always_comb begin
      busy        = (state == ST_BUSY);
      stall_req   = (start && is_long_op(md_op)) || busy;
      accept_long = (state == ST_IDLE) && start && is_long_op(md_op);
      accept_mthi = (state == ST_IDLE) && start && (md_op == MD_MTHI);
      accept_mtlo = (state == ST_IDLE) && start && (md_op == MD_MTLO);
      complete    = (state == ST_BUSY) && (cnt == CNT_W'(1));
   end

   // Counter, pending result and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         if (accept_long) begin
            cnt     <= is_mult ? MULT_LOAD : DIV_LOAD;
            pend_hi <= arith_res[63:32];
            pend_lo <= arith_res[31:0];
         end else if (state == ST_BUSY) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (complete) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (accept_mthi) hi <= src_a;
         if (accept_mtlo) lo <= src_a;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected results computed
// with plain 64-bit arithmetic; a monitor checks busy length, HI/LO hold
// while busy, and the committed result when busy drops.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      logic [31:0] new_hi;
      logic [31:0] new_lo;
      int          cycles;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Monitor: one sample per cycle, 1 ns after the rising edge
   initial begin : monitor
      int   run;
      logic prev_busy;
      exp_t e;
      run = 0;
      prev_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            run = 0;
            prev_busy = 1'b0;
         end else begin
            if (busy) begin
               run++;
               if (sb_q.size() == 0) begin
                  check("busy_unexpected", 32'(busy), 32'd0);
               end else begin
                  check("hold_hi", hi, sb_q[0].old_hi);
                  check("hold_lo", lo, sb_q[0].old_lo);
               end
               check("stall_while_busy", 32'(stall_req), 32'd1);
            end else if (prev_busy) begin
               if (sb_q.size() == 0) begin
                  check("spurious_done", 32'(prev_busy), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("busy_cycles", 32'(run), 32'(e.cycles));
                  check("result_hi", hi, e.new_hi);
                  check("result_lo", lo, e.new_lo);
               end
               run = 0;
            end
            prev_busy = busy;
         end
      end
   end

   // Reference model plus drive; inputs change on the falling edge
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t               e;
      longint             sa, sbv, sp, sq, sr;
      longint unsigned    ua, ub, up, uq, ur;
      logic               is_long;
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      src_a = a;
      src_b = b;
      is_long = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
      #1;
      check("stall_start", 32'(stall_req), is_long ? 32'd1 : 32'd0);
      e.old_hi = m_hi;
      e.old_lo = m_lo;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      case (op)
         MD_MULT: begin
            sp = sa * sbv;
            m_hi = sp[63:32];
            m_lo = sp[31:0];
         end
         MD_MULTU: begin
            up = ua * ub;
            m_hi = up[63:32];
            m_lo = up[31:0];
         end
         MD_DIV: if (b != 32'd0) begin
            sq = sa / sbv;
            sr = sa % sbv;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
         end
         MD_DIVU: if (b != 32'd0) begin
            uq = ua / ub;
            ur = ua % ub;
            m_lo = uq[31:0];
            m_hi = ur[31:0];
         end
         MD_MTHI: m_hi = a;
         MD_MTLO: m_lo = a;
         default: ;
      endcase
      if (is_long) begin
         e.new_hi = m_hi;
         e.new_lo = m_lo;
         e.cycles = ((op == MD_MULT) || (op == MD_MULTU)) ? 5 : 10;
         sb_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      md_op = MD_NONE;
      if (!is_long) begin
         check("short_hi", hi, m_hi);
         check("short_lo", lo, m_lo);
         check("short_busy", 32'(busy), 32'd0);
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy || sb_q.size() != 0) && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (k >= 40) check("idle_timeout", 32'(sb_q.size()) + 32'(busy), 32'd0);
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'($urandom_range(1, 20));
         2:       return -32'($urandom_range(1, 20));
         3:       return 32'h8000_0000;
         4:       return 32'hFFFF_FFFF;
         default: return $urandom();
      endcase
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [2:0] op;
      reset = 1'b0;
      start = 1'b0;
      md_op = MD_NONE;
      src_a = '0;
      src_b = '0;
      m_hi  = '0;
      m_lo  = '0;
      #2;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_stall", 32'(stall_req), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Signed multiply
      issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
      wait_idle();
      check("mult_neg_hi", hi, 32'hFFFF_FFFF);
      check("mult_neg_lo", lo, 32'hFFFF_FFFA);

      // Unsigned multiply, old values held while busy
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle();
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);

      // Signed divide
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("div_neg_lo", lo, 32'hFFFF_FFFD);
      check("div_neg_hi", hi, 32'hFFFF_FFFF);

      // MTHI/MTLO then divide by zero
      issue(MD_MTHI, 32'h0000_1234, 32'd0);
      issue(MD_MTLO, 32'h0000_5678, 32'd0);
      issue(MD_DIVU, 32'd100, 32'd0);
      wait_idle();
      check("divz_hi", hi, 32'h0000_1234);
      check("divz_lo", lo, 32'h0000_5678);

      // NONE has no effect
      issue(MD_NONE, 32'hDEAD_BEEF, 32'd1);

      // Start during BUSY is ignored
      issue(MD_MULT, 32'd7, 32'd6);
      @(negedge clk);
      start = 1'b1;
      md_op = MD_DIV;
      src_a = 32'd99;
      src_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      md_op = MD_NONE;
      wait_idle();
      check("ignore_busy_after", 32'(busy), 32'd0);

      // Start coinciding with the final BUSY edge is ignored
      issue(MD_MULT, 32'd3, 32'd3);
      repeat (4) @(negedge clk);
      start = 1'b1;
      md_op = MD_DIV;
      src_a = 32'd50;
      src_b = 32'd7;
      @(negedge clk);
      check("late_start_ignored", 32'(busy), 32'd0);
      start = 1'b0;
      md_op = MD_NONE;
      wait_idle();
      check("late_start_hi", hi, 32'd0);
      check("late_start_lo", lo, 32'd9);

      // Overflow divide aborted by reset mid-busy
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      sb_q.delete();
      m_hi = '0;
      m_lo = '0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_stays_idle", 32'(busy), 32'd0);
      check("abort_no_commit", lo, 32'd0);

      // Overflow divide, uninterrupted
      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);

      // Random mix
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 6));
         issue(op, rand_opnd(), rand_opnd());
         wait_idle();
      end
      check("final_hi", hi, m_hi);
      check("final_lo", lo, m_lo);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
